mod_m_counter_ud: RTL and testbench
===================================

// Module: mod_m_counter_ud
//
// PURPOSE
//   Parametrised up/down modulo-M counter with a run-time programmable modulus,
//   synchronous clear and parallel load. It has wrap or saturate end behaviour
//   and a registered terminal-count pulse.
//   It is the general time-base and prescaler block for the debounce, baud and
//   display-scan logic. Several instances can be chained through wrap_o -> en_i.
//
// PARAMETERS
//   Width     4   counter, top and load width in bits (Width >= 2)
//   Modulus   10  reset-time modulus M; top register resets to Modulus-1
//                 (2 <= Modulus <= 2**Width)
//   Saturate  0   0: wrap at the boundary; 1: hold at the boundary
//
// PORTS
//   clk_i      in   1      clock, all state changes on rising edge
//   rst_i      in   1      asynchronous reset, active high
//   en_i       in   1      count enable; one step per enabled cycle
//   up_i       in   1      direction: 1 = increment, 0 = decrement
//   clr_i      in   1      synchronous clear to 0
//   load_i     in   1      synchronous parallel load of load_val_i
//   load_val_i in   Width  load value (clamped to top)
//   top_wr_i   in   1      write a new terminal value top_i (= M-1)
//   top_i      in   Width  new terminal value; 0 is illegal
//   cnt_o      out  Width  current count, range 0..top
//   wrap_o     out  1      registered one-cycle pulse: the boundary was crossed
//   at_top_o   out  1      level: cnt_o == active top
//   at_zero_o  out  1      level: cnt_o == 0
//   pend_o     out  1      level: a top write is pending
//
// BEHAVIOUR
//   Reset (async, rst_i=1)
//     - cnt=0, top=Modulus-1, pending top cleared, wrap_o=0, pend_o=0.
//   Priority per cycle: clr_i > load_i > en_i
//     - If none of these is asserted, cnt holds.
//   clr_i
//     - cnt<=0; any pending top becomes active; wrap_o<=0.
//   load_i
//     - cnt<=min(load_val_i, top_active_after_apply).
//     - Pending top is applied first, then the clamp uses the new top.
//     - wrap_o<=0.
//   en_i, up_i=1
//     - cnt<top: cnt+1.
//     - cnt==top, Saturate=0: cnt<=0 and wrap_o<=1 next cycle.
//     - cnt==top, Saturate=1: cnt holds and wrap_o<=1 on every enabled cycle
//       at top.
//     - cnt>top: only possible transiently; treated as ==top.
//   en_i, up_i=0
//     - cnt>0: cnt-1.
//     - cnt==0, Saturate=0: cnt<=top and wrap_o<=1.
//     - cnt==0, Saturate=1: cnt holds and wrap_o<=1.
//   Boundary event
//     - Boundary crossing (wrap or saturate hit), clr_i or load_i applies
//       pending top.
//     - A down-wrap loads the newly applied top.
//   top_wr_i
//     - top_i==0 is ignored: no pending, no change.
//     - Otherwise top_i is stored as pending and pend_o<=1.
//     - A later write overwrites an earlier pending value.
//     - top_wr_i in the same cycle as an apply event: top_i is applied directly,
//       pend_o stays 0.
//   wrap_o
//     - Registered; it is high in the cycle in which cnt_o shows the post-wrap
//       value.
//     - Latency is 1 cycle from the enabled boundary edge.
//   at_top_o and at_zero_o
//     - Combinational from cnt and the active top.
//     - With top=1 both flags toggle each cycle.
//   Arithmetic
//     - Unsigned, Width bits. No intermediate overflow, since wrap is decided
//       by compare, not by carry.
//   Asynchronous reset mid-count
//     - Counter immediately returns to the reset state.
//     - Pending top is lost and top returns to Modulus-1.
//
// TESTING
//   1. Reset, en_i=1, up_i=1, Modulus=10 for 12 cycles
//      -> cnt 0..9,0,1; wrap_o high only with cnt_o=0 after 9.
//   2. Down from 0, en_i=1, up_i=0
//      -> cnt 9,8,...; wrap_o pulses with cnt_o=9; at_zero_o before it.
//   3. Saturate=1, up from 7
//      -> 8,9,9,9; wrap_o high every enabled cycle at 9; down from 0 holds 0.
//   4. At cnt=3 write top_i=4; count up
//      -> pend_o=1; 4..9 continue under old top; wrap to 0; new sequence
//         0..4, wrap; pend_o=0 after the wrap.
//   5. load_i=1 with load_val_i=15 while top=9 and clr_i=0
//      -> cnt=9; same cycle with clr_i=1 -> cnt=0; top_i=0 write ignored.
//   6. Assert rst_i mid-count with a pending top
//      -> cnt=0, top=9, pend_o=0, wrap_o=0 immediately; counting resumes
//         when rst_i is released.

Source files
------------

// File: rtl/mod_m_counter_ud.sv
// Up/down modulo-M counter with run-time programmable terminal value, sync clear,
// parallel load, wrap/saturate end behaviour and a registered boundary pulse.
module mod_m_counter_ud #(
    parameter int Width    = 4,
    parameter int Modulus  = 10,
    parameter int Saturate = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             up_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             top_wr_i,
    input  logic [Width-1:0] top_i,
    output logic [Width-1:0] cnt_o,
    output logic             wrap_o,
    output logic             at_top_o,
    output logic             at_zero_o,
    output logic             pend_o
);

    logic [Width-1:0] r_cnt;
    logic [Width-1:0] r_top;
    logic [Width-1:0] r_pend_val;
    logic             r_pend;
    logic             r_wrap;

    logic             w_top_wr_ok;
    logic [Width-1:0] w_new_top;
    logic             w_step;
    logic             w_hit;
    logic             w_apply;
    logic [Width-1:0] w_load_clamped;
    logic [Width-1:0] w_cnt_nxt;

    // A same-cycle top write beats the pending value when a boundary applies it.
    always_comb begin
        w_top_wr_ok    = top_wr_i && (top_i != '0);
        w_new_top      = w_top_wr_ok ? top_i : (r_pend ? r_pend_val : r_top);
        w_step         = en_i && !clr_i && !load_i;
        w_hit          = up_i ? (r_cnt >= r_top) : (r_cnt == '0);
        w_apply        = clr_i || load_i || (w_step && w_hit);
        w_load_clamped = (load_val_i > w_new_top) ? w_new_top : load_val_i;
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (clr_i) begin
            w_cnt_nxt = '0;
        end else if (load_i) begin
            w_cnt_nxt = w_load_clamped;
        end else if (en_i) begin
            if (up_i) begin
                if (!w_hit)
                    w_cnt_nxt = r_cnt + Width'(1);
                else if (Saturate != 0)
                    // Holding must not leave the count above a freshly shrunk top.
                    w_cnt_nxt = (r_cnt > w_new_top) ? w_new_top : r_cnt;
                else
                    w_cnt_nxt = '0;
            end else begin
                if (!w_hit)
                    w_cnt_nxt = r_cnt - Width'(1);
                else if (Saturate != 0)
                    w_cnt_nxt = r_cnt;
                else
                    w_cnt_nxt = w_new_top;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt      <= '0;
            r_top      <= Width'(Modulus - 1);
            r_pend_val <= '0;
            r_pend     <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_wrap <= w_step && w_hit;
            if (w_apply) begin
                r_top  <= w_new_top;
                r_pend <= 1'b0;
            end else if (w_top_wr_ok) begin
                r_pend_val <= top_i;
                r_pend     <= 1'b1;
            end
        end
    end

    assign cnt_o     = r_cnt;
    assign wrap_o    = r_wrap;
    assign at_top_o  = (r_cnt == r_top);
    assign at_zero_o = (r_cnt == '0);
    assign pend_o    = r_pend;

endmodule

// File: tb/tb_mod_m_counter_ud.sv
// Directed bench for mod_m_counter_ud: wrap instance plus a saturating instance
// sharing the same stimulus.
module tb_mod_m_counter_ud;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0, up = 1'b1, clr = 1'b0, load = 1'b0, top_wr = 1'b0;
    logic [3:0] load_val = '0, top_v = '0;
    logic [3:0] cnt, s_cnt;
    logic       wrap, at_top, at_zero, pend;
    logic       s_wrap, s_at_top, s_at_zero, s_pend;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mod_m_counter_ud #(.Width(4), .Modulus(10), .Saturate(0)) u_dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .clr_i(clr),
        .load_i(load), .load_val_i(load_val), .top_wr_i(top_wr), .top_i(top_v),
        .cnt_o(cnt), .wrap_o(wrap), .at_top_o(at_top), .at_zero_o(at_zero),
        .pend_o(pend));

    mod_m_counter_ud #(.Width(4), .Modulus(10), .Saturate(1)) u_sat (
        .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .clr_i(clr),
        .load_i(load), .load_val_i(load_val), .top_wr_i(top_wr), .top_i(top_v),
        .cnt_o(s_cnt), .wrap_o(s_wrap), .at_top_o(s_at_top), .at_zero_o(s_at_zero),
        .pend_o(s_pend));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 0; up = 1; clr = 0; load = 0; top_wr = 0; load_val = '0; top_v = '0;
    endtask

    task automatic do_reset();
        idle();
        #2 rst = 1;
        #3 rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({cnt, wrap, at_top, at_zero, pend} !== {4'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL reset: cnt=%0d wrap=%b top=%b zero=%b pend=%b, want 0 0 0 1 0",
                     cnt, wrap, at_top, at_zero, pend);
        end
    endtask

    task automatic test_count_up();
        logic [3:0] exp_c;
        do_reset();
        en = 1; up = 1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            exp_c = 4'(i % 10);
            n_cmp++;
            if (cnt !== exp_c || wrap !== (exp_c == 0) || at_top !== (exp_c == 9)) begin
                n_bad++;
                $display("FAIL up[%0d]: cnt=%0d wrap=%b at_top=%b, want %0d %b %b",
                         i, cnt, wrap, at_top, exp_c, exp_c == 0, exp_c == 9);
            end
        end
        idle();
    endtask

    task automatic test_count_down();
        logic [3:0] exp_c;
        do_reset();
        en = 1; up = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_c = 4'(9 - i);
            n_cmp++;
            if (cnt !== exp_c || wrap !== (i == 0) || at_zero !== 1'b0) begin
                n_bad++;
                $display("FAIL down[%0d]: cnt=%0d wrap=%b zero=%b, want %0d %b 0",
                         i, cnt, wrap, at_zero, exp_c, i == 0);
            end
        end
        idle();
    endtask

    task automatic test_saturate();
        logic [3:0] exp_c [4] = '{4'd8, 4'd9, 4'd9, 4'd9};
        logic       exp_w [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        load = 1; load_val = 4'd7;
        tick();
        load = 0; en = 1; up = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (s_cnt !== exp_c[i] || s_wrap !== exp_w[i]) begin
                n_bad++;
                $display("FAIL sat_up[%0d]: cnt=%0d wrap=%b, want %0d %b",
                         i, s_cnt, s_wrap, exp_c[i], exp_w[i]);
            end
        end
        en = 0; clr = 1;
        tick();
        clr = 0; en = 1; up = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (s_cnt !== 4'd0 || s_wrap !== 1'b1 || s_at_zero !== 1'b1) begin
                n_bad++;
                $display("FAIL sat_dn[%0d]: cnt=%0d wrap=%b zero=%b, want 0 1 1",
                         i, s_cnt, s_wrap, s_at_zero);
            end
        end
        idle();
    endtask

    task automatic test_pending_top();
        logic [3:0] exp_c;
        logic       exp_w, exp_p;
        do_reset();
        load = 1; load_val = 4'd3;
        tick();
        load = 0; top_wr = 1; top_v = 4'd4;
        tick();
        top_wr = 0; top_v = '0;
        n_cmp++;
        if (cnt !== 4'd3 || pend !== 1'b1) begin
            n_bad++;
            $display("FAIL pend_set: cnt=%0d pend=%b, want 3 1", cnt, pend);
        end
        en = 1; up = 1;
        // 4..9 under old top, wrap to 0, then 1..4 under new top, wrap to 0
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_c = (i < 6) ? 4'(4 + i) : (i == 6) ? 4'd0 : (i < 11) ? 4'(i - 6) : 4'd0;
            exp_w = (i == 6) || (i == 11);
            exp_p = (i < 6);
            n_cmp++;
            if (cnt !== exp_c || wrap !== exp_w || pend !== exp_p) begin
                n_bad++;
                $display("FAIL pend_seq[%0d]: cnt=%0d wrap=%b pend=%b, want %0d %b %b",
                         i, cnt, wrap, pend, exp_c, exp_w, exp_p);
            end
        end
        idle();
    endtask

    task automatic test_load_clr();
        do_reset();
        load = 1; load_val = 4'd15;
        tick();
        n_cmp++;
        if (cnt !== 4'd9 || at_top !== 1'b1 || wrap !== 1'b0) begin
            n_bad++;
            $display("FAIL load_clamp: cnt=%0d at_top=%b wrap=%b, want 9 1 0", cnt, at_top, wrap);
        end
        clr = 1;
        tick();
        n_cmp++;
        if (cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL clr_over_load: cnt=%0d, want 0", cnt);
        end
        clr = 0; load = 0; top_wr = 1; top_v = 4'd0;
        tick();
        top_wr = 0; load = 1; load_val = 4'd15;
        tick();
        n_cmp++;
        if (pend !== 1'b0 || cnt !== 4'd9) begin
            n_bad++;
            $display("FAIL top_zero_ignored: pend=%b cnt=%0d, want 0 9", pend, cnt);
        end
        // top write alongside clear takes effect directly
        load = 0; clr = 1; top_wr = 1; top_v = 4'd5;
        tick();
        clr = 0; top_wr = 0; load = 1; load_val = 4'd15;
        tick();
        n_cmp++;
        if (pend !== 1'b0 || cnt !== 4'd5 || at_top !== 1'b1) begin
            n_bad++;
            $display("FAIL top_with_clr: pend=%b cnt=%0d at_top=%b, want 0 5 1", pend, cnt, at_top);
        end
        // top=1: both flags toggle every cycle
        load = 0; clr = 1; top_wr = 1; top_v = 4'd1;
        tick();
        clr = 0; top_wr = 0; en = 1; up = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (cnt !== 4'(1 - (i % 2)) || at_top !== (i % 2 == 0) || at_zero !== (i % 2 == 1)
                || wrap !== (i % 2 == 1)) begin
                n_bad++;
                $display("FAIL top1[%0d]: cnt=%0d top=%b zero=%b wrap=%b",
                         i, cnt, at_top, at_zero, wrap);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid_count();
        do_reset();
        load = 1; load_val = 4'd9;
        tick();
        load = 0; top_wr = 1; top_v = 4'd4; en = 1; up = 1;
        tick();
        top_wr = 0; top_v = '0; en = 0;
        n_cmp++;
        if (wrap !== 1'b1 || cnt !== 4'd0 || pend !== 1'b0) begin
            n_bad++;
            $display("FAIL pre_rst_wrap: wrap=%b cnt=%0d pend=%b, want 1 0 0", wrap, cnt, pend);
        end
        top_wr = 1; top_v = 4'd4; en = 1;
        tick();
        top_wr = 0; top_v = '0;
        tick();
        rst = 1;
        #1;
        n_cmp++;
        if (cnt !== 4'd0 || pend !== 1'b0 || wrap !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_async: cnt=%0d pend=%b wrap=%b, want 0 0 0", cnt, pend, wrap);
        end
        #2 rst = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_cmp++;
            if (cnt !== 4'(i % 10) || wrap !== (i == 10)) begin
                n_bad++;
                $display("FAIL rst_resume[%0d]: cnt=%0d wrap=%b, want %0d %b",
                         i, cnt, wrap, i % 10, i == 10);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_saturate();
        test_pending_top();
        test_load_clr();
        test_reset_mid_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
